// File: rtl/e_mdu_param_pkg.sv
// Shared definitions for the parametrised HI/LO multiply/divide unit:
// opcode constants and helpers reused by the MDU and the hazard unit.
package e_mdu_param_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] OP_MFHI  = 4'd5;
    localparam logic [OP_W-1:0] OP_MFLO  = 4'd6;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'd7;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'd8;
    localparam logic [OP_W-1:0] OP_MADD  = 4'd9;
    localparam logic [OP_W-1:0] OP_MADDU = 4'd10;
    localparam logic [OP_W-1:0] OP_MSUB  = 4'd11;
    localparam logic [OP_W-1:0] OP_MSUBU = 4'd12;

    // True for every opcode that occupies the unit for a multi-cycle latency.
    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT)  || (op == OP_MULTU) ||
               (op == OP_DIV)   || (op == OP_DIVU)  ||
               (op == OP_MADD)  || (op == OP_MADDU) ||
               (op == OP_MSUB)  || (op == OP_MSUBU);
    endfunction

    // True for the long ops that use the divide latency.
    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_param_arith.sv
// Combinational datapath of the MDU: computes the full {HI,LO} result of a
// long op from the operands and the current HI/LO, including the defined
// divide-by-zero and signed-overflow results.
module e_mdu_arith
    import e_mdu_param_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [W2-1:0]    acc;
    logic [W2-1:0]    prod_s;
    logic [W2-1:0]    prod_u;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] div_u;
    logic [WIDTH-1:0] div_s;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] sq;
    logic [WIDTH-1:0] sr;

    // Products and quotients; signed division works on magnitudes and then
    // restores the C truncation signs (remainder follows the dividend).
    // Zero divisors are replaced by one so the dividers never see zero; the
    // special-case mux below supplies the real result.
    always_comb begin
        acc    = {hi, lo};
        prod_s = {{WIDTH{rs[WIDTH-1]}}, rs} * {{WIDTH{rt[WIDTH-1]}}, rt};
        prod_u = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};
        abs_a  = rs[WIDTH-1] ? (~rs + ONE) : rs;
        abs_b  = rt[WIDTH-1] ? (~rt + ONE) : rt;
        div_u  = (rt == '0) ? ONE : rt;
        div_s  = (abs_b == '0) ? ONE : abs_b;
        uq     = rs / div_u;
        ur     = rs % div_u;
        q_mag  = abs_a / div_s;
        r_mag  = abs_a % div_s;
        sq     = (rs[WIDTH-1] ^ rt[WIDTH-1]) ? (~q_mag + ONE) : q_mag;
        sr     = rs[WIDTH-1] ? (~r_mag + ONE) : r_mag;
    end

    // Select the result for the presented opcode.
    always_comb begin
        {res_hi, res_lo} = '0;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_MADD:  {res_hi, res_lo} = acc + prod_s;
            OP_MADDU: {res_hi, res_lo} = acc + prod_u;
            OP_MSUB:  {res_hi, res_lo} = acc - prod_s;
            OP_MSUBU: {res_hi, res_lo} = acc - prod_u;
            OP_DIV: begin
                if (rt == '0) begin
                    res_hi = rs;
                    res_lo = ALL_ONE;
                end else if ((rs == MIN_NEG) && (rt == ALL_ONE)) begin
                    res_hi = '0;
                    res_lo = MIN_NEG;
                end else begin
                    res_hi = sr;
                    res_lo = sq;
                end
            end
            OP_DIVU: begin
                if (rt == '0) begin
                    res_hi = rs;
                    res_lo = ALL_ONE;
                end else begin
                    res_hi = ur;
                    res_lo = uq;
                end
            end
            default: {res_hi, res_lo} = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu_param.sv
// E-stage HI/LO multiply/divide unit with configurable width and latencies.
// A long op computes its result at issue into temporaries, counts down the
// configured latency, then commits to HI/LO. cancel kills the in-flight op.
module e_mdu_param
    import e_mdu_param_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [OP_W-1:0]  op,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] result
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] tmp_hi;
    logic [WIDTH-1:0] tmp_lo;
    logic [CW-1:0]    count;
    logic             busy_q;
    logic [WIDTH-1:0] arith_hi;
    logic [WIDTH-1:0] arith_lo;

    e_mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .rs     (rs),
        .rt     (rt),
        .op     (op),
        .hi     (hi),
        .lo     (lo),
        .res_hi (arith_hi),
        .res_lo (arith_lo)
    );

    // Issue, countdown, commit and cancel; reset overrides everything and
    // cancel overrides issue, commit and MTHI/MTLO writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            tmp_hi <= '0;
            tmp_lo <= '0;
            count  <= '0;
            busy_q <= 1'b0;
        end else if (cancel) begin
            tmp_hi <= '0;
            tmp_lo <= '0;
            count  <= '0;
            busy_q <= 1'b0;
        end else if (count == '0) begin
            if (is_long_op(op)) begin
                tmp_hi <= arith_hi;
                tmp_lo <= arith_lo;
                count  <= is_div_op(op) ? DIV_CNT : MUL_CNT;
                busy_q <= 1'b1;
            end else if (op == OP_MTHI) begin
                hi <= rs;
            end else if (op == OP_MTLO) begin
                lo <= rs;
            end
        end else if (count == CNT_ONE) begin
            hi     <= tmp_hi;
            lo     <= tmp_lo;
            count  <= '0;
            busy_q <= 1'b0;
        end else begin
            count <= count - CNT_ONE;
        end
    end

    // Stall request to the hazard unit and the MFHI/MFLO read port.
    always_comb begin
        busy   = is_long_op(op) | busy_q;
        result = '0;
        if (op == OP_MFHI) begin
            result = hi;
        end else if (op == OP_MFLO) begin
            result = lo;
        end
    end

endmodule

// File: tb/tb_e_mdu_param.sv
// Bench for e_mdu_param: a 32-bit default instance checked every cycle
// against a 64-bit integer model, plus a 16-bit short-latency instance
// checked with literal expectations.
module tb_e_mdu_param;
    import e_mdu_param_pkg::*;

    localparam int A_MUL = 5;
    localparam int A_DIV = 10;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [3:0]  t_op;
    logic [31:0] t_rs;
    logic [31:0] t_rt;
    logic        t_cancel;

    logic [3:0]  a_op;
    logic        a_cancel;
    logic        a_busy;
    logic [31:0] a_result;
    logic [3:0]  b_op;
    logic        b_cancel;
    logic        b_busy;
    logic [15:0] b_result;
    logic        t_busy;
    logic [31:0] t_result;

    int nCompared;
    int nMismatched;
    int cyc;

    assign a_op     = sel ? OP_NONE : t_op;
    assign a_cancel = sel ? 1'b0 : t_cancel;
    assign b_op     = sel ? t_op : OP_NONE;
    assign b_cancel = sel ? t_cancel : 1'b0;
    assign t_busy   = sel ? b_busy : a_busy;
    assign t_result = sel ? {16'h0, b_result} : a_result;

    e_mdu_param dutA (
        .clk    (clk),
        .reset  (reset),
        .rs     (t_rs),
        .rt     (t_rt),
        .op     (a_op),
        .cancel (a_cancel),
        .busy   (a_busy),
        .result (a_result)
    );

    e_mdu_param #(
        .WIDTH   (16),
        .MUL_LAT (1),
        .DIV_LAT (3)
    ) dutB (
        .clk    (clk),
        .reset  (reset),
        .rs     (t_rs[15:0]),
        .rt     (t_rt[15:0]),
        .op     (b_op),
        .cancel (b_cancel),
        .busy   (b_busy),
        .result (b_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: full-width integer arithmetic on 64-bit values.
    function automatic logic [63:0] modelResult(input logic [3:0] o, input logic [31:0] x,
                                                input logic [31:0] y, input logic [31:0] h,
                                                input logic [31:0] l);
        longint      sx, sy, sq, sr;
        logic [63:0] ux, uy, sp, up, acc, uq, ur;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'h0, x};
        uy  = {32'h0, y};
        sp  = 64'(sx * sy);
        up  = ux * uy;
        acc = {h, l};
        case (o)
            OP_MULT:  return sp;
            OP_MULTU: return up;
            OP_MADD:  return acc + sp;
            OP_MADDU: return acc + up;
            OP_MSUB:  return acc - sp;
            OP_MSUBU: return acc - up;
            OP_DIV: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sq = sx / sy;
                sr = sx % sy;
                return {sr[31:0], sq[31:0]};
            end
            OP_DIVU: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic bit modelLong(input logic [3:0] o);
        return o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    // Model of instance A: architectural HI/LO plus one pending result that
    // lands at the end of cycle issue+latency; outputs checked every cycle.
    logic [31:0] mHi, mLo, pHi, pLo;
    bit          pend;
    int          commitCyc;
    logic [63:0] mr;

    initial begin
        mHi = 0; mLo = 0; pHi = 0; pLo = 0; pend = 0; commitCyc = 0;
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            checkOutput("busy", {63'h0, a_busy}, {63'h0, modelLong(a_op) || pend});
            checkOutput("result", {32'h0, a_result},
                        {32'h0, (a_op == OP_MFHI) ? mHi : (a_op == OP_MFLO) ? mLo : 32'h0});
            if (!reset) begin
                mHi = 0; mLo = 0; pend = 0;
            end else if (a_cancel) begin
                pend = 0;
            end else if (!pend) begin
                if (modelLong(a_op)) begin
                    mr        = modelResult(a_op, t_rs, t_rt, mHi, mLo);
                    pHi       = mr[63:32];
                    pLo       = mr[31:0];
                    pend      = 1;
                    commitCyc = cyc + ((a_op == OP_DIV || a_op == OP_DIVU) ? A_DIV : A_MUL);
                end else if (a_op == OP_MTHI) begin
                    mHi = t_rs;
                end else if (a_op == OP_MTLO) begin
                    mLo = t_rs;
                end
            end else if (cyc == commitCyc) begin
                mHi  = pHi;
                mLo  = pLo;
                pend = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic c);
        t_op     = o;
        t_rs     = x;
        t_rt     = y;
        t_cancel = c;
    endtask

    // Issue a long op and count the cycles busy stays high (issue cycle included).
    task automatic issueLong(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                             input int expBusy, input string nm);
        int n;
        n = 0;
        applyStimulus(o, x, y, 1'b0);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!t_busy) break;
            n++;
            tick();
            t_op = OP_NONE;
        end
        checkOutput({nm, " busy cycles"}, 64'(n), 64'(expBusy));
        tick();
    endtask

    task automatic waitIdle(input string nm);
        int n;
        n = 0;
        t_op = OP_NONE;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!t_busy) break;
            n++;
            tick();
        end
        if (n >= 64) checkOutput({nm, " idle timeout"}, 64'(n), 64'(0));
        tick();
    endtask

    task automatic readHiLo(input logic [31:0] eh, input logic [31:0] el, input string nm);
        applyStimulus(OP_MFHI, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput({nm, " HI"}, {32'h0, t_result}, {32'h0, eh});
        tick();
        t_op = OP_MFLO;
        @(negedge clk);
        checkOutput({nm, " LO"}, {32'h0, t_result}, {32'h0, el});
        tick();
        t_op = OP_NONE;
    endtask

    initial begin
        nCompared = 0; nMismatched = 0; cyc = 0;
        sel = 1'b0; reset = 1'b0;
        applyStimulus(OP_NONE, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        readHiLo(32'h0, 32'h0, "after reset");

        issueLong(OP_MULT, 32'hFFFF_FFFE, 32'd3, 6, "mult");
        readHiLo(32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        issueLong(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, "multu");
        readHiLo(32'hFFFF_FFFE, 32'h0000_0001, "multu");
        issueLong(OP_MADDU, 32'd1, 32'd1, 6, "maddu");
        readHiLo(32'hFFFF_FFFE, 32'h0000_0002, "maddu");
        issueLong(OP_MSUB, 32'd2, 32'd1, 6, "msub");
        readHiLo(32'hFFFF_FFFE, 32'h0000_0000, "msub");

        issueLong(OP_DIV, 32'hFFFF_FFF9, 32'd2, 11, "div");
        readHiLo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        issueLong(OP_DIVU, 32'd7, 32'd0, 11, "divu by zero");
        readHiLo(32'h0000_0007, 32'hFFFF_FFFF, "divu by zero");
        issueLong(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 11, "div overflow");
        readHiLo(32'h0000_0000, 32'h8000_0000, "div overflow");
        issueLong(OP_DIV, 32'd7, 32'hFFFF_FFFE, 11, "div neg divisor");
        readHiLo(32'h0000_0001, 32'hFFFF_FFFD, "div neg divisor");
        issueLong(OP_DIV, 32'hFFFF_FFFB, 32'd0, 11, "div by zero");
        readHiLo(32'hFFFF_FFFB, 32'hFFFF_FFFF, "div by zero");

        applyStimulus(OP_MTHI, 32'h1234, 32'h0, 1'b0);
        tick();
        applyStimulus(OP_MTLO, 32'h5678, 32'h0, 1'b0);
        tick();
        readHiLo(32'h1234, 32'h5678, "mthi/mtlo");

        // DIV cancelled on its commit edge (count==1 in cycle T+10).
        applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0);
        tick();
        t_op = OP_NONE;
        repeat (9) tick();
        t_cancel = 1'b1;
        tick();
        t_cancel = 1'b0;
        @(negedge clk);
        checkOutput("cancel at commit busy", {63'h0, t_busy}, 64'h0);
        tick();
        readHiLo(32'h1234, 32'h5678, "cancel at commit");

        applyStimulus(OP_MULT, 32'd5, 32'd5, 1'b1);
        tick();
        applyStimulus(OP_NONE, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("cancel with issue busy", {63'h0, t_busy}, 64'h0);
        tick();
        readHiLo(32'h1234, 32'h5678, "cancel with issue");

        applyStimulus(OP_MTHI, 32'hBEEF, 32'h0, 1'b1);
        tick();
        applyStimulus(OP_NONE, 32'h0, 32'h0, 1'b0);
        readHiLo(32'h1234, 32'h5678, "cancel with mthi");

        // Ops presented while busy are ignored.
        applyStimulus(OP_MULTU, 32'd2, 32'd3, 1'b0);
        tick();
        t_op = OP_NONE;
        tick();
        applyStimulus(OP_MTHI, 32'h9999, 32'h0, 1'b0);
        tick();
        applyStimulus(OP_DIVU, 32'd1, 32'd1, 1'b0);
        tick();
        waitIdle("ignored ops");
        readHiLo(32'h0, 32'h6, "ignored ops");

        issueLong(OP_MADD, 32'hFFFF_FFFF, 32'd2, 6, "madd");
        readHiLo(32'h0, 32'h4, "madd");
        issueLong(OP_MSUBU, 32'hFFFF_FFFF, 32'd1, 6, "msubu");
        readHiLo(32'hFFFF_FFFF, 32'h0000_0005, "msubu");

        // Reset in the middle of a MULT, with an ignored MTLO before it.
        applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b0);
        tick();
        t_op = OP_NONE;
        tick();
        applyStimulus(OP_MTLO, 32'hAAAA, 32'h0, 1'b0);
        tick();
        t_op  = OP_NONE;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid reset busy", {63'h0, t_busy}, 64'h0);
        checkOutput("mid reset result", {32'h0, t_result}, 64'h0);
        tick();
        readHiLo(32'h0, 32'h0, "mid reset");

        // 16-bit instance, MUL_LAT=1, DIV_LAT=3.
        sel = 1'b1;
        issueLong(OP_MULT, 32'h8000, 32'h8000, 2, "w16 mult");
        readHiLo(32'h4000, 32'h0000, "w16 mult");
        issueLong(OP_DIVU, 32'd100, 32'd7, 4, "w16 divu");
        readHiLo(32'd2, 32'd14, "w16 divu");
        issueLong(OP_DIV, 32'h8000, 32'hFFFF, 4, "w16 div overflow");
        readHiLo(32'h0000, 32'h8000, "w16 div overflow");
        sel = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/e_mdu_param.md
Name: e_mdu_param

Overview:
- Parametrised successor to the E-stage HI/LO multiply/divide unit in the pipelined MIPS core.
- Supports WIDTH-bit operands, independent multiply and divide latencies, and multiply-accumulate/subtract (madd/maddu/msub/msubu).
- Defines results for divide-by-zero and signed overflow.
- Adds a cancel input so an in-flight operation can be killed on exception/flush; the control unit uses busy to stall mfhi/mflo/md ops in D.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LAT, 5, countdown cycles after issue for mult/multu/madd*/msub* (must be >= 1).
- DIV_LAT, 10, countdown cycles after issue for div/divu (must be >= 1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (clears when 0 at posedge clk).
- rs  in  WIDTH  operand A, already forwarded.
- rt  in  WIDTH  operand B, already forwarded.
- op  in  4  MDU opcode (package constants); presented for exactly one cycle per instruction.
- cancel  in  1  aborts in-flight op at next edge; HI/LO keep architectural values.
- busy  out  1  combinational: (op is a long op) | busy_q.
- result  out  WIDTH  HI when op==MFHI, LO when op==MFLO, else 0.

Behaviour:
- Reset (reset==0 at edge): HI=LO=0, tmp_hi=tmp_lo=0, count=0, busy_q=0. Hence busy=0 while op=NONE, and result=0.
- Long ops: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
- Issue, only when count==0 and cancel==0 at edge T:
  - Compute full 2*WIDTH result into tmp_hi/tmp_lo.
  - Load count=MUL_LAT or DIV_LAT; set busy_q=1.
- Countdown: count>1 decrements. At count==1 the edge commits HI<=tmp_hi, LO<=tmp_lo, count<=0, busy_q<=0.
- Timing: busy is high in cycles T..T+LAT; new HI/LO are readable from cycle T+LAT+1.
- MTHI/MTLO: when count==0, HI<=rs or LO<=rs at edge; result visible next cycle. Ignored while count!=0; the stall rule forbids issue in that case.
- Any op while count!=0 is ignored and leaves state unchanged (assertion in bench).
- Arithmetic, with P = 2*WIDTH product:
  - MULT: sign-extended operands. MULTU: zero-extended operands.
  - MADD/MADDU: {HI,LO} + P. MSUB/MSUBU: {HI,LO} - P. Modulo 2^(2*WIDTH); sign of P per signed/unsigned variant; {HI,LO} sampled at issue.
- DIV/DIVU: LO=quotient, HI=remainder; C truncation semantics, remainder takes the dividend's sign.
- Divide by zero (rt==0): LO = all ones, HI = rs, same latency.
- Signed overflow (rs = MIN, rt = -1): LO=MIN, HI=0.
- cancel: if asserted at an edge, count<=0, busy_q<=0, tmp discarded, HI/LO unchanged.
  - cancel together with an issuing op: op is not accepted.
  - cancel on the commit edge (count==1): commit suppressed.
  - cancel with MTHI/MTLO: write suppressed.
- reset mid-operation: reset wins over everything; state returns to reset values.
- mfhi/mflo while busy_q=1 return old HI/LO; the hazard unit stalls them, so this is never architecturally consumed.
- count register width: $clog2(max(MUL_LAT,DIV_LAT)+1).

Decomposition:
- Shared header (Define.v): MDU opcode constants NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12. Also a helper macro for "is long op", reused by the hazard unit.
- Sub-module e_mdu_arith: combinational, parametrised by WIDTH.
  - Inputs: rs, rt, op, HI, LO.
  - Output: {res_hi, res_lo}, including the zero/overflow special cases.
  - The top holds the counter, temp registers, HI/LO and cancel logic.

Test Plan:
- Reset then MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 6 cycles; cycle T+6 MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MADDU rs=1, rt=1 -> HI=0xFFFFFFFE, LO=0x00000002. Then MSUB rs=2, rt=1 -> LO=0x00000000.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy 11 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- MTHI 0x1234 then MTLO 0x5678 -> MFHI=0x1234, MFLO=0x5678. Then DIV issued, cancel pulsed at count==1 -> HI/LO still 0x1234/0x5678, busy low next cycle.
- During MULT, present MTLO 0xAAAA at T+2 and reset=0 at T+3 -> MTLO ignored; after reset HI=LO=0, busy=0, result=0.
- Parameter sweep WIDTH=16, MUL_LAT=1, DIV_LAT=3: MULT 0x8000*0x8000 -> HI=0x4000, LO=0x0000, busy exactly 2 cycles; DIVU 100/7 -> LO=14, HI=2, busy 4 cycles.
